// File: rtl/gated_bus_pkg.sv
// Shared types and constants for the gated bus controller.
// Optional macro GATED_BUS_PRIORITY_EN is consumed by gated_bus_ctrl.
package gated_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

    // Saturating increment used by the conflict counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? CNT_MAX : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// Classifies a gate vector as zero / one-hot / multi-hot and finds its lowest set bit.
module onehot_decode #(
    parameter int NSRC  = 4,
    parameter int IDX_W = $clog2(NSRC)
) (
    input  logic [NSRC-1:0]  gate,
    output logic             is_zero,
    output logic             is_onehot,
    output logic [IDX_W-1:0] low_idx
);

    assign is_zero   = (gate == '0);
    assign is_onehot = !is_zero && ((gate & (gate - NSRC'(1))) == '0);

    // Scan downward so the last hit is the lowest set index.
    always_comb begin
        low_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (gate[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/gated_bus_ctrl.sv
// Registered bus multiplexer driven by per-source gates with conflict detection.
// Define GATED_BUS_PRIORITY_EN to resolve multi-hot gates to the lowest index.
module gated_bus_ctrl
    import gated_bus_pkg::*;
#(
    parameter int              WIDTH      = 16,
    parameter int              NSRC       = 4,
    parameter logic [WIDTH-1:0] IDLE_VALUE = '0,
    localparam int             IDX_W      = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NSRC-1:0]       gate,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic                  hold_en,
    input  logic                  clr_cnt,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  bus_valid,
    output logic [IDX_W-1:0]      owner,
    output logic                  conflict,
    output logic [CNT_W-1:0]      conflict_cnt,
    output state_t                state
);

    logic             is_zero;
    logic             is_onehot;
    logic             is_multi;
    logic [IDX_W-1:0] low_idx;
    logic [WIDTH-1:0] sel_data;
    logic             go_drive;

    onehot_decode #(
        .NSRC  (NSRC),
        .IDX_W (IDX_W)
    ) u_decode (
        .gate      (gate),
        .is_zero   (is_zero),
        .is_onehot (is_onehot),
        .low_idx   (low_idx)
    );

    assign is_multi = !is_zero && !is_onehot;

`ifdef GATED_BUS_PRIORITY_EN
    assign go_drive = !is_zero;
`else
    assign go_drive = is_onehot;
`endif

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (low_idx == IDX_W'(i)) begin
                sel_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // FAULT is sticky until one all-zero gate cycle releases it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            bus_out      <= IDLE_VALUE;
            bus_valid    <= 1'b0;
            owner        <= '0;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            conflict <= is_multi;
            if (clr_cnt) begin
                conflict_cnt <= is_multi ? CNT_W'(1) : '0;
            end else if (is_multi) begin
                conflict_cnt <= sat_inc(conflict_cnt);
            end

            if (is_zero) begin
                state     <= ST_IDLE;
                bus_valid <= 1'b0;
                owner     <= '0;
                if (!hold_en) begin
                    bus_out <= IDLE_VALUE;
                end
            end else if (state != ST_FAULT && go_drive) begin
                state     <= ST_DRIVE;
                bus_valid <= 1'b1;
                owner     <= low_idx;
                bus_out   <= sel_data;
            end else begin
                state     <= ST_FAULT;
                bus_valid <= 1'b0;
                owner     <= '0;
                bus_out   <= IDLE_VALUE;
            end
        end
    end

endmodule

// File: tb/tb_gated_bus_ctrl.sv
// Table-driven self-checking bench for gated_bus_ctrl (NSRC=4, WIDTH=16).
// Expectations follow GATED_BUS_PRIORITY_EN when it is defined.
module tb_gated_bus_ctrl;
    import gated_bus_pkg::*;

    localparam int WIDTH = 16;
    localparam int NSRC  = 4;

`ifdef GATED_BUS_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic                  clk;
    logic                  reset_n;
    logic [NSRC-1:0]       gate;
    logic [NSRC*WIDTH-1:0] src_data;
    logic                  hold_en;
    logic                  clr_cnt;
    logic [WIDTH-1:0]      bus_out;
    logic                  bus_valid;
    logic [1:0]            owner;
    logic                  conflict;
    logic [7:0]            conflict_cnt;
    state_t                state;

    int checks   = 0;
    int failures = 0;

    gated_bus_ctrl #(
        .WIDTH      (WIDTH),
        .NSRC       (NSRC),
        .IDLE_VALUE (16'h0000)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .gate         (gate),
        .src_data     (src_data),
        .hold_en      (hold_en),
        .clr_cnt      (clr_cnt),
        .bus_out      (bus_out),
        .bus_valid    (bus_valid),
        .owner        (owner),
        .conflict     (conflict),
        .conflict_cnt (conflict_cnt),
        .state        (state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  gate;
        logic        hold;
        logic        clr;
        logic [15:0] exp_bus;
        logic        exp_valid;
        logic [1:0]  exp_owner;
        logic        exp_conflict;
        logic [7:0]  exp_cnt;
        state_t      exp_state;
    } vec_t;

    vec_t vecs[40];
    int   nvec = 0;

    task automatic add(input logic rst_n, input logic [3:0] g, input logic hold, input logic clr,
                       input logic [15:0] eb, input logic ev, input logic [1:0] eo,
                       input logic ec, input logic [7:0] en, input state_t es);
        vecs[nvec] = '{rst_n, g, hold, clr, eb, ev, eo, ec, en, es};
        nvec++;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input vec_t v);
        check("bus_out", idx, 32'(bus_out), 32'(v.exp_bus));
        check("bus_valid", idx, 32'(bus_valid), 32'(v.exp_valid));
        check("owner", idx, 32'(owner), 32'(v.exp_owner));
        check("conflict", idx, 32'(conflict), 32'(v.exp_conflict));
        check("conflict_cnt", idx, 32'(conflict_cnt), 32'(v.exp_cnt));
        check("state", idx, 32'(state), 32'(v.exp_state));
    endtask

    // Driver: apply inputs on the falling edge, sample 1 time unit after the rising edge.
    task automatic drive(input logic rst_n, input logic [3:0] g, input logic hold, input logic clr);
        @(negedge clk);
        reset_n = rst_n;
        gate    = g;
        hold_en = hold;
        clr_cnt = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        gate     = '0;
        hold_en  = 1'b0;
        clr_cnt  = 1'b0;
        src_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};

        //   rst gate     hold clr  bus                         valid        owner           conf cnt    state
        add(0, 4'b0000, 0, 0, 16'h0000, 0, 2'd0, 0, 8'd0, ST_IDLE);
        add(1, 4'b0100, 0, 0, 16'hCCCC, 1, 2'd2, 0, 8'd0, ST_DRIVE);
        add(1, 4'b0001, 1, 0, 16'hAAAA, 1, 2'd0, 0, 8'd0, ST_DRIVE);
        add(1, 4'b0000, 1, 0, 16'hAAAA, 0, 2'd0, 0, 8'd0, ST_IDLE);
        add(1, 4'b0000, 1, 0, 16'hAAAA, 0, 2'd0, 0, 8'd0, ST_IDLE);
        add(1, 4'b0001, 0, 0, 16'hAAAA, 1, 2'd0, 0, 8'd0, ST_DRIVE);
        add(1, 4'b0000, 0, 0, 16'h0000, 0, 2'd0, 0, 8'd0, ST_IDLE);
        add(1, 4'b1000, 0, 0, 16'hDDDD, 1, 2'd3, 0, 8'd0, ST_DRIVE);
        add(1, 4'b0010, 0, 0, 16'hBBBB, 1, 2'd1, 0, 8'd0, ST_DRIVE);
        add(1, 4'b0110, 1, 0, PRIO ? 16'hBBBB : 16'h0000, PRIO, PRIO ? 2'd1 : 2'd0, 1, 8'd1, PRIO ? ST_DRIVE : ST_FAULT);
        add(1, 4'b0110, 1, 0, PRIO ? 16'hBBBB : 16'h0000, PRIO, PRIO ? 2'd1 : 2'd0, 1, 8'd2, PRIO ? ST_DRIVE : ST_FAULT);
        add(1, 4'b0110, 1, 0, PRIO ? 16'hBBBB : 16'h0000, PRIO, PRIO ? 2'd1 : 2'd0, 1, 8'd3, PRIO ? ST_DRIVE : ST_FAULT);
        add(1, 4'b0010, 1, 0, PRIO ? 16'hBBBB : 16'h0000, PRIO, PRIO ? 2'd1 : 2'd0, 0, 8'd3, PRIO ? ST_DRIVE : ST_FAULT);
        add(1, 4'b0000, 0, 0, 16'h0000, 0, 2'd0, 0, 8'd3, ST_IDLE);
        add(1, 4'b0000, 0, 1, 16'h0000, 0, 2'd0, 0, 8'd0, ST_IDLE);
        add(1, 4'b1000, 0, 0, 16'hDDDD, 1, 2'd3, 0, 8'd0, ST_DRIVE);
        add(0, 4'b1000, 1, 1, 16'h0000, 0, 2'd0, 0, 8'd0, ST_IDLE);
        add(1, 4'b1000, 0, 0, 16'hDDDD, 1, 2'd3, 0, 8'd0, ST_DRIVE);
        add(1, 4'b1111, 0, 0, PRIO ? 16'hAAAA : 16'h0000, PRIO, 2'd0, 1, 8'd1, PRIO ? ST_DRIVE : ST_FAULT);
        add(1, 4'b0001, 0, 0, PRIO ? 16'hAAAA : 16'h0000, PRIO, 2'd0, 0, 8'd1, PRIO ? ST_DRIVE : ST_FAULT);
        add(1, 4'b0000, 1, 0, PRIO ? 16'hAAAA : 16'h0000, 0, 2'd0, 0, 8'd1, ST_IDLE);
        add(1, 4'b0011, 0, 0, PRIO ? 16'hAAAA : 16'h0000, PRIO, 2'd0, 1, 8'd2, PRIO ? ST_DRIVE : ST_FAULT);
        add(0, 4'b0011, 1, 0, 16'h0000, 0, 2'd0, 0, 8'd0, ST_IDLE);
        add(1, 4'b0000, 1, 0, 16'h0000, 0, 2'd0, 0, 8'd0, ST_IDLE);

        for (int i = 0; i < nvec; i++) begin
            drive(vecs[i].rst_n, vecs[i].gate, vecs[i].hold, vecs[i].clr);
            check_all(i, vecs[i]);
        end

        // Saturation: 300 consecutive multi-hot cycles starting from a zero count.
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 4'b0011, 1'b0, 1'b0);
            check("conflict_pulse", 100 + i, 32'(conflict), 32'd1);
            if (i == 253) check("cnt_254", 100 + i, 32'(conflict_cnt), 32'd254);
            if (i == 254) check("cnt_sat", 100 + i, 32'(conflict_cnt), 32'd255);
        end
        check("cnt_hold_255", 400, 32'(conflict_cnt), 32'd255);

        // Clear together with a conflict loads one; clear alone loads zero.
        drive(1'b1, 4'b0101, 1'b0, 1'b1);
        check("clr_with_conflict", 401, 32'(conflict_cnt), 32'd1);
        check("clr_conflict_pulse", 401, 32'(conflict), 32'd1);
        drive(1'b1, 4'b0000, 1'b0, 1'b1);
        check("clr_alone", 402, 32'(conflict_cnt), 32'd0);
        check("clr_idle_state", 402, 32'(state), 32'(ST_IDLE));
        check("clr_no_conflict", 402, 32'(conflict), 32'd0);

        // Direct DRIVE to DRIVE owner switch keeps bus_valid high.
        drive(1'b1, 4'b0100, 1'b0, 1'b0);
        check("sw_owner_a", 403, 32'(owner), 32'd2);
        drive(1'b1, 4'b0001, 1'b0, 1'b0);
        check("sw_owner_b", 404, 32'(owner), 32'd0);
        check("sw_valid", 404, 32'(bus_valid), 32'd1);
        check("sw_bus", 404, 32'(bus_out), 32'hAAAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gated_bus_ctrl.md
GATED_BUS_CTRL -- requirements
Module: gated_bus_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, bus data width in bits.
REQ-002 Parameter NSRC, default 4, number of gated sources (2..16).
REQ-003 Parameter IDLE_VALUE, default 0 (WIDTH bits), bus value when no valid owner.
REQ-004 Clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Reset_n  in  1  reset, synchronous, active-low.
REQ-006 gate  in  NSRC  per-source gate request; bit i means "source i drives bus".
REQ-007 src_data  in  NSRC*WIDTH  packed source data; source i occupies bits [i*WIDTH +: WIDTH].
REQ-008 hold_en  in  1  when 1, bus_out retains last driven value while no source is gated.
REQ-009 clr_cnt  in  1  synchronous clear of conflict_cnt.
REQ-010 bus_out  out  WIDTH  registered bus value.
REQ-011 bus_valid  out  1  registered; 1 when bus_out holds data from a single valid owner.
REQ-012 owner  out  $clog2(NSRC)  registered index of current owner; 0 when bus_valid=0.
REQ-013 conflict  out  1  registered one-cycle pulse per cycle in which gate had more than one bit set.
REQ-014 conflict_cnt  out  8  saturating count of conflict cycles.

Function
REQ-015 Latency SHALL be exactly one cycle from gate/src_data sample to bus_out/bus_valid/owner/conflict.
REQ-016 FSM states SHALL be IDLE, DRIVE, FAULT.
REQ-017 IDLE/DRIVE: gate==0 -> IDLE; gate one-hot -> DRIVE; gate multi-hot -> FAULT.
REQ-018 FAULT: remain while gate!=0; gate==0 for one cycle -> IDLE (release handshake); one-hot while in FAULT does not exit.
REQ-019 Entering or in DRIVE: bus_out=src_data of gated source, owner=its index, bus_valid=1.
REQ-020 Entering or in IDLE: bus_valid=0, owner=0; bus_out=IDLE_VALUE if hold_en=0, else previous bus_out unchanged.
REQ-021 Entering or in FAULT: bus_valid=0, owner=0, bus_out=IDLE_VALUE regardless of hold_en.
REQ-022 conflict SHALL be 1 in the cycle following every sampled multi-hot gate, including repeats while in FAULT.
REQ-023 conflict_cnt SHALL increment by 1 per conflict cycle, saturate at 255, never wrap.
REQ-024 clr_cnt=1 with simultaneous conflict event SHALL load conflict_cnt=1; clr_cnt alone loads 0.
REQ-025 Source change DRIVE->DRIVE (one-hot to a different one-hot) SHALL switch owner in one cycle with bus_valid staying 1.

Reset
REQ-026 Reset_n=0 at a rising edge SHALL force state=IDLE, bus_out=IDLE_VALUE, bus_valid=0, owner=0, conflict=0, conflict_cnt=0.
REQ-027 Reset asserted mid-DRIVE or mid-FAULT SHALL take precedence over all inputs including clr_cnt and hold_en.
REQ-028 First cycle after reset release SHALL evaluate gate normally per REQ-017.

Configuration
REQ-029 Macro GATED_BUS_PRIORITY_EN, when defined, SHALL resolve multi-hot gate to the lowest set index (treated as DRIVE, bus_valid=1); conflict and conflict_cnt still update; FAULT unreachable.
REQ-030 Without GATED_BUS_PRIORITY_EN, multi-hot behaviour SHALL be per REQ-017/018/021.

Structure
REQ-031 Package gated_bus_pkg SHALL hold the state enum typedef, CNT_W=8 and CNT_MAX=255.
REQ-032 Sub-module onehot_decode SHALL compute is_zero, is_onehot, lowest set index from gate; gated_bus_ctrl instantiates it once.

Verification (NSRC=4, WIDTH=16)
REQ-033 src_data={4'hD,C,B,A repeated: 16'hDDDD,CCCC,BBBB,AAAA}, gate=4'b0100 -> next cycle bus_out=16'hCCCC, owner=2, bus_valid=1.
REQ-034 gate 4'b0001 then 4'b0000 with hold_en=1 -> bus_out stays 16'hAAAA, bus_valid=0; repeat with hold_en=0 -> bus_out=16'h0000.
REQ-035 gate=4'b0110 for 3 cycles, then 4'b0010, then 4'b0000 -> conflict high 3 cycles, conflict_cnt=3, FAULT held through 4'b0010, IDLE after 4'b0000; with GATED_BUS_PRIORITY_EN owner=1, bus_out=16'hBBBB.
REQ-036 300 consecutive multi-hot cycles -> conflict_cnt=255 and holds; clr_cnt with conflict same cycle -> conflict_cnt=1.
REQ-037 Reset_n=0 during DRIVE with gate=4'b1000 -> next cycle all outputs at reset values; release -> bus_out=16'hDDDD one cycle later.
